timer_tima: RTL

- Programmable timer that consumes the divider's frequency taps (4096/262144/65536/16384 Hz).
- Implements TIMA (FF05), TMA (FF06) and TAC (FF07).
- Counts on falling edges of the selected, enabled tap; reloads from TMA on overflow and raises the timer interrupt request.
- Sits beside the clock/reset/divider page: the divider generates the taps, this block consumes them and drives the interrupt controller and CPU data bus.

---
 rtl/timer_tima.sv | 128 ++++++++++++
 1 files changed

// File: rtl/timer_tima.sv
// Programmable TIMA/TMA/TAC timer: counts falling edges of a selected divider tap,
// reloads from TMA after overflow and pulses the timer interrupt request.
module timer_tima #(
  parameter logic [4:0] TAC_PAD      = 5'b11111,
  parameter int         RELOAD_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] div_taps,
  input  logic       ff05_ff07,
  input  logic [1:0] a,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       int_timer,
  output logic [7:0] tima_q
);

  typedef enum logic [1:0] {IDLE, PENDING, RELOAD} state_t;

  localparam logic [1:0] ARM = 2'(RELOAD_DELAY - 1);

  state_t     state, state_nx;
  logic [7:0] tima, tima_nx;
  logic [7:0] tma;
  logic [2:0] tac;
  logic       tap_prev;
  logic [1:0] cnt, cnt_nx;

  logic       tap, gated, tick;
  logic       wr_hit, wr_tima, wr_tma, wr_tac;
  logic [8:0] tima_inc;

  // Gating before edge detection makes disabling or re-selecting a high tap look like a falling edge.
  assign tap      = div_taps[tac[1:0]];
  assign gated    = tac[2] & tap;
  assign tick     = tap_prev & ~gated;
  assign wr_hit   = ff05_ff07 & cpu_wr;
  assign wr_tima  = wr_hit & (a == 2'b01);
  assign wr_tma   = wr_hit & (a == 2'b10);
  assign wr_tac   = wr_hit & (a == 2'b11);
  assign tima_inc = {1'b0, tima} + 9'd1;

  always_comb begin
    state_nx = state;
    tima_nx  = tima;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_nx = d_in;
        end else if (tick) begin
          tima_nx = tima_inc[7:0];
          if (tima_inc[8]) begin
            state_nx = PENDING;
            cnt_nx   = ARM;
          end
        end
      end
      PENDING: begin
        if (wr_tima) begin
          tima_nx  = d_in;
          state_nx = IDLE;
        end else if (cnt == 2'd0) begin
          // The reload takes this edge; a coincident tick is dropped.
          tima_nx  = tma;
          state_nx = RELOAD;
        end else begin
          cnt_nx = cnt - 2'd1;
          if (tick) begin
            tima_nx = tima_inc[7:0];
            if (tima_inc[8]) cnt_nx = ARM;
          end
        end
      end
      RELOAD: begin
        state_nx = IDLE;
        if (wr_tma) begin
          tima_nx = d_in;
        end else if (tick) begin
          tima_nx = tima_inc[7:0];
          if (tima_inc[8]) begin
            state_nx = PENDING;
            cnt_nx   = ARM;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tima     <= 8'h00;
      tma      <= 8'h00;
      tac      <= 3'b000;
      tap_prev <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      state    <= state_nx;
      tima     <= tima_nx;
      cnt      <= cnt_nx;
      tap_prev <= gated;
      if (wr_tma) tma <= d_in;
      if (wr_tac) tac <= d_in[2:0];
    end
  end

  assign int_timer = (state == RELOAD);
  assign tima_q    = tima;
  assign d_oe      = ff05_ff07 & cpu_rd & (a != 2'b00);

  always_comb begin
    d_out = 8'h00;
    if (d_oe) begin
      case (a)
        2'b01:   d_out = tima;
        2'b10:   d_out = tma;
        2'b11:   d_out = {TAC_PAD, tac};
        default: d_out = 8'h00;
      endcase
    end
  end

endmodule
